// File: rtl/vector_fetch_sequencer_if.sv
// Bus bundle between the vector fetch sequencer, interrupt/reset control,
// the external data bus and the PC register.
interface vector_fetch_sequencer_if;
  logic       req_reset;
  logic       req_nmi;
  logic       req_irq;
  logic       ready;
  logic [7:0] data_in;
  logic [7:0] address_lowbyte;
  logic [7:0] address_highbyte;
  logic       read_enable;
  logic [7:0] pc_lowbyte;
  logic [7:0] pc_highbyte;
  logic       pc_load;
  logic       busy;
  logic       set_interrupt_disable;

  // The sequencer is the bus master; the surrounding control/memory is the slave.
  modport master (
    input  req_reset, req_nmi, req_irq, ready, data_in,
    output address_lowbyte, address_highbyte, read_enable,
           pc_lowbyte, pc_highbyte, pc_load, busy, set_interrupt_disable
  );

  modport slave (
    output req_reset, req_nmi, req_irq, ready, data_in,
    input  address_lowbyte, address_highbyte, read_enable,
           pc_lowbyte, pc_highbyte, pc_load, busy, set_interrupt_disable
  );
endinterface

// File: rtl/vector_fetch_sequencer.sv
// Fetches a 16-bit RESET/NMI/IRQ vector as two byte reads and strobes it
// into the program counter.
module vector_fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
  input  logic                           clk,
  input  logic                           rst,
  vector_fetch_sequencer_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_LOW  = 2'd1,
    FETCH_HIGH = 2'd2,
    LOAD       = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic        reset_fetch_q, reset_fetch_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic [7:0]  low_q, low_d;
  logic [7:0]  high_q, high_d;
  logic [15:0] fetch_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      reset_fetch_q <= 1'b0;
      nmi_pending_q <= 1'b0;
      low_q         <= '0;
      high_q        <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      reset_fetch_q <= reset_fetch_d;
      nmi_pending_q <= nmi_pending_d;
      low_q         <= low_d;
      high_q        <= high_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    reset_fetch_d = reset_fetch_q;
    // Any NMI pulse not accepted this cycle is remembered for the next IDLE.
    nmi_pending_d = nmi_pending_q | bus.req_nmi;
    low_d         = low_q;
    high_d        = high_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_reset) begin
          base_d        = RESET_VECTOR;
          reset_fetch_d = 1'b1;
          state_d       = FETCH_LOW;
        end else if (bus.req_nmi || nmi_pending_q) begin
          base_d        = NMI_VECTOR;
          reset_fetch_d = 1'b0;
          nmi_pending_d = 1'b0;
          state_d       = FETCH_LOW;
        end else if (bus.req_irq) begin
          base_d        = IRQ_VECTOR;
          reset_fetch_d = 1'b0;
          state_d       = FETCH_LOW;
        end
      end
      FETCH_LOW, FETCH_HIGH: begin
        // A reset request restarts a non-reset fetch; bytes already read are simply overwritten.
        if (bus.req_reset && !reset_fetch_q) begin
          base_d        = RESET_VECTOR;
          reset_fetch_d = 1'b1;
          state_d       = FETCH_LOW;
        end else if (bus.ready) begin
          if (state_q == FETCH_LOW) begin
            low_d   = bus.data_in;
            state_d = FETCH_HIGH;
          end else begin
            high_d  = bus.data_in;
            state_d = LOAD;
          end
        end
      end
      LOAD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_addr                = (state_q == FETCH_HIGH) ? base_q + 16'd1 : base_q;
    bus.read_enable           = (state_q == FETCH_LOW) || (state_q == FETCH_HIGH);
    bus.address_lowbyte       = bus.read_enable ? fetch_addr[7:0]  : '0;
    bus.address_highbyte      = bus.read_enable ? fetch_addr[15:8] : '0;
    bus.pc_lowbyte            = low_q;
    bus.pc_highbyte           = high_q;
    bus.pc_load               = (state_q == LOAD);
    bus.set_interrupt_disable = (state_q == LOAD);
    bus.busy                  = (state_q != IDLE);
  end

endmodule

// File: tb/tb_vector_fetch_sequencer.sv
// Directed bench for vector_fetch_sequencer: hand-computed addresses, strobes
// and assembled targets checked once per cycle on the falling edge.
module tb_vector_fetch_sequencer;
  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_errors;

  vector_fetch_sequencer_if bus ();

  vector_fetch_sequencer #(
    .RESET_VECTOR (16'hFFFC),
    .NMI_VECTOR   (16'hFFFA),
    .IRQ_VECTOR   (16'hFFFE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'hCD;
      16'hFFFB: return 8'hAB;
      16'hFFFC: return 8'h34;
      16'hFFFD: return 8'h12;
      16'hFFFE: return 8'h78;
      16'hFFFF: return 8'h56;
      default:  return 8'hEE;
    endcase
  endfunction

  // While ready is low the bus carries junk, so an early capture is visible.
  assign bus.data_in = bus.ready ? mem_rd({bus.address_highbyte, bus.address_lowbyte}) : 8'hA5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_fetch(input string tag, input logic [15:0] addr);
    check({tag, ".addr"}, {16'h0, bus.address_highbyte, bus.address_lowbyte}, {16'h0, addr});
    check({tag, ".re"},   {31'h0, bus.read_enable}, 32'd1);
    check({tag, ".busy"}, {31'h0, bus.busy}, 32'd1);
    check({tag, ".load"}, {31'h0, bus.pc_load}, 32'd0);
  endtask

  task automatic chk_load(input string tag, input logic [15:0] pc);
    check({tag, ".load"}, {31'h0, bus.pc_load}, 32'd1);
    check({tag, ".sid"},  {31'h0, bus.set_interrupt_disable}, 32'd1);
    check({tag, ".pc"},   {16'h0, bus.pc_highbyte, bus.pc_lowbyte}, {16'h0, pc});
    check({tag, ".re"},   {31'h0, bus.read_enable}, 32'd0);
    check({tag, ".addr"}, {16'h0, bus.address_highbyte, bus.address_lowbyte}, 32'd0);
    check({tag, ".busy"}, {31'h0, bus.busy}, 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".busy"}, {31'h0, bus.busy}, 32'd0);
    check({tag, ".load"}, {31'h0, bus.pc_load}, 32'd0);
    check({tag, ".sid"},  {31'h0, bus.set_interrupt_disable}, 32'd0);
    check({tag, ".re"},   {31'h0, bus.read_enable}, 32'd0);
    check({tag, ".addr"}, {16'h0, bus.address_highbyte, bus.address_lowbyte}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.req_reset = 1'b0;
    bus.req_nmi   = 1'b0;
    bus.req_irq   = 1'b0;
    bus.ready     = 1'b1;
    cyc(); cyc();
    chk_idle("rst");
    check("rst.pc", {16'h0, bus.pc_highbyte, bus.pc_lowbyte}, 32'd0);
    rst = 1'b0;
    cyc();
    chk_idle("idle0");

    // Reset vector fetch, ready always high
    bus.req_reset = 1'b1;
    cyc(); bus.req_reset = 1'b0;
    chk_fetch("t1.lo", 16'hFFFC);
    cyc(); chk_fetch("t1.hi", 16'hFFFD);
    cyc(); chk_load("t1.ld", 16'h1234);
    cyc(); chk_idle("t1.end");
    check("t1.hold", {16'h0, bus.pc_highbyte, bus.pc_lowbyte}, 32'h1234);

    // IRQ fetch with stalls: 2 in FETCH_LOW, 1 in FETCH_HIGH
    bus.req_irq = 1'b1;
    cyc(); bus.req_irq = 1'b0; bus.ready = 1'b0;
    chk_fetch("t3.lo0", 16'hFFFE);
    cyc(); chk_fetch("t3.lo1", 16'hFFFE);
    bus.ready = 1'b0;
    cyc(); chk_fetch("t3.lo2", 16'hFFFE);
    bus.ready = 1'b1;
    cyc(); chk_fetch("t3.hi0", 16'hFFFF);
    bus.ready = 1'b0;
    cyc(); chk_fetch("t3.hi1", 16'hFFFF);
    bus.ready = 1'b1;
    cyc(); chk_load("t3.ld", 16'h5678);
    cyc(); chk_idle("t3.end");

    // Simultaneous requests: reset, then pending NMI, then level IRQ
    bus.req_reset = 1'b1; bus.req_nmi = 1'b1; bus.req_irq = 1'b1;
    cyc(); bus.req_reset = 1'b0; bus.req_nmi = 1'b0;
    chk_fetch("t2.rlo", 16'hFFFC);
    cyc(); chk_fetch("t2.rhi", 16'hFFFD);
    cyc(); chk_load("t2.rld", 16'h1234);
    cyc(); chk_idle("t2.gap1");
    cyc(); chk_fetch("t2.nlo", 16'hFFFA);
    cyc(); chk_fetch("t2.nhi", 16'hFFFB);
    cyc(); chk_load("t2.nld", 16'hABCD);
    cyc(); chk_idle("t2.gap2");
    cyc(); chk_fetch("t2.ilo", 16'hFFFE);
    bus.req_irq = 1'b0;
    cyc(); chk_fetch("t2.ihi", 16'hFFFF);
    cyc(); chk_load("t2.ild", 16'h5678);
    cyc(); chk_idle("t2.end");
    cyc(); chk_idle("t2.quiet");

    // NMI pulse during IRQ fetch is deferred
    bus.req_irq = 1'b1;
    cyc(); bus.req_irq = 1'b0; bus.req_nmi = 1'b1;
    chk_fetch("t4.ilo", 16'hFFFE);
    cyc(); bus.req_nmi = 1'b0;
    chk_fetch("t4.ihi", 16'hFFFF);
    cyc(); chk_load("t4.ild", 16'h5678);
    cyc(); chk_idle("t4.gap");
    cyc(); chk_fetch("t4.nlo", 16'hFFFA);
    cyc(); chk_fetch("t4.nhi", 16'hFFFB);
    cyc(); chk_load("t4.nld", 16'hABCD);
    cyc(); chk_idle("t4.end");

    // Reset request aborts IRQ fetch in FETCH_HIGH
    bus.req_irq = 1'b1;
    cyc(); bus.req_irq = 1'b0;
    chk_fetch("t5.ilo", 16'hFFFE);
    cyc(); chk_fetch("t5.ihi", 16'hFFFF);
    bus.req_reset = 1'b1;
    cyc(); bus.req_reset = 1'b0;
    chk_fetch("t5.rlo", 16'hFFFC);
    cyc(); chk_fetch("t5.rhi", 16'hFFFD);
    cyc(); chk_load("t5.rld", 16'h1234);
    cyc(); chk_idle("t5.end");

    // rst mid-fetch also drops a pending NMI
    bus.req_irq = 1'b1;
    cyc(); bus.req_irq = 1'b0; bus.req_nmi = 1'b1;
    chk_fetch("t6.ilo", 16'hFFFE);
    cyc(); bus.req_nmi = 1'b0;
    chk_fetch("t6.ihi", 16'hFFFF);
    rst = 1'b1;
    cyc(); rst = 1'b0;
    chk_idle("t6.rst");
    check("t6.pc", {16'h0, bus.pc_highbyte, bus.pc_lowbyte}, 32'd0);
    bus.req_irq = 1'b1;
    cyc(); bus.req_irq = 1'b0;
    chk_fetch("t6.lo", 16'hFFFE);
    cyc(); chk_fetch("t6.hi", 16'hFFFF);
    cyc(); chk_load("t6.ld", 16'h5678);
    cyc(); chk_idle("t6.end");
    cyc(); chk_idle("t6.nonmi");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
